// File: rtl/dot_matrix_pkg.sv
// Shared constants for the dot-matrix scanner: pattern ROM contents, index width
// and the pattern-step rule applied on debounced key presses.
package dot_matrix_pkg;
  localparam int PAT_W    = 2;
  localparam int PAT_N    = 4;
  localparam int ROM_ROWS = 8;

  typedef logic [PAT_W-1:0] pat_t;

  // One 64-bit word per pattern, row r in bits [8r+7:8r].
  localparam logic [PAT_N-1:0][63:0] PAT_ROM = {
    64'h55AA_55AA_55AA_55AA,   // 3: checker
    64'hFFFF_FFFF_FFFF_FFFF,   // 2: all on
    64'h8181_423C_0066_6600,   // 1: frown
    64'h3C42_8181_0066_6600    // 0: smile
  };

  // prs = {next, prev}; both at once cancel.
  function automatic pat_t pat_step(input pat_t cur, input logic [1:0] prs);
    case (prs)
      2'b10:   return pat_t'(cur + 1'b1);
      2'b01:   return pat_t'(cur - 1'b1);
      default: return cur;
    endcase
  endfunction
endpackage

// File: rtl/dot_matrix_scanner_if.sv
// Per-key bundle between the raw pushbutton and its debouncer.
interface dot_matrix_scanner_if #(parameter int W = 1);
  logic [W-1:0] raw;
  logic [W-1:0] press;

  modport master (output raw, input press);
  modport slave  (input raw, output press);
endinterface

// File: rtl/dot_matrix_scanner_key_debounce.sv
// Single-key debouncer: level follows raw after 2^DEB_BITS stable clocks,
// with a one-clock press pulse on each debounced rising transition.
module key_debounce #(
  parameter int DEB_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dot_matrix_scanner_if.slave   kif
);
  logic [DEB_BITS-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                press_q, press_d;

  // Any clock where raw agrees with the level clears the run, so bounces restart it.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (kif.raw[0] != level_q) begin
      if (&cnt_q) begin
        level_d = kif.raw[0];
        press_d = kif.raw[0];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign kif.press = press_q;
endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-scanned LED matrix driver with per-slot blanking, frame blink and
// debounced next/prev pattern selection applied only at frame boundaries.
module dot_matrix_scanner
  import dot_matrix_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int SCAN_DIV  = 13,
  parameter int BLANK     = 16,
  parameter int DEB_BITS  = 16,
  parameter int BLINK_BIT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       key_in,
  input  logic             blink,
  output logic             key,
  output logic [ROWS-1:0]  en,
  output logic [COLS-1:0]  dataout,
  output logic [PAT_W-1:0] pat_idx
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = BLINK_BIT + 1;
  localparam logic [SCAN_DIV-1:0] BLANK_W = SCAN_DIV'(BLANK);
  localparam logic [RW-1:0]       LAST_ROW = RW'(ROWS - 1);

  logic [SCAN_DIV-1:0] slot_q, slot_d;
  logic [RW-1:0]       row_q, row_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic [ROWS-1:0]     en_q, en_d;
  logic [COLS-1:0]     dout_q, dout_d;
  pat_t                pat_q, pat_d;
  pat_t                pend_q, pend_d;
  logic [1:0]          press;
  logic                blank;

  for (genvar k = 0; k < 2; k++) begin : g_key
    dot_matrix_scanner_if #(.W(1)) kif ();
    assign kif.raw = key_in[k];
    key_debounce #(.DEB_BITS(DEB_BITS)) u_deb (
      .clk (clk),
      .rst (rst),
      .kif (kif.slave)
    );
    assign press[k] = kif.press[0];
  end

  // Rows beyond the ROM read as dark; columns are truncated or zero-extended.
  function automatic logic [COLS-1:0] rom_data(input pat_t p, input logic [RW-1:0] r);
    logic [15:0] w;
    w = '0;
    if (int'(r) < ROM_ROWS) w[7:0] = PAT_ROM[p][int'(r)*8 +: 8];
    return w[COLS-1:0];
  endfunction

  assign blank = (slot_q < BLANK_W) || (blink && frame_q[BLINK_BIT]);

  always_comb begin
    slot_d  = slot_q + 1'b1;
    row_d   = row_q;
    frame_d = frame_q;
    if (&slot_q) begin
      if (row_q == LAST_ROW) begin
        row_d   = '0;
        frame_d = frame_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end

    en_d   = '1;
    dout_d = '0;
    if (!blank) begin
      en_d[row_q] = 1'b0;
      dout_d      = rom_data(pat_q, row_q);
    end

    // Swap only when the frame restarts so a frame never mixes two patterns.
    pat_d  = (slot_q == '0 && row_q == '0) ? pend_q : pat_q;
    pend_d = pat_step(pend_q, press);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q  <= '0;
      row_q   <= '0;
      frame_q <= '0;
      en_q    <= '1;
      dout_q  <= '0;
      pat_q   <= '0;
      pend_q  <= '0;
    end else begin
      slot_q  <= slot_d;
      row_q   <= row_d;
      frame_q <= frame_d;
      en_q    <= en_d;
      dout_q  <= dout_d;
      pat_q   <= pat_d;
      pend_q  <= pend_d;
    end
  end

  assign key     = 1'b0;
  assign en      = en_q;
  assign dataout = dout_q;
  assign pat_idx = pat_q;
endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Self-checking bench for dot_matrix_scanner: cycle-count reference model plus
// a table of scan vectors and directed key/reset/blink sequences.
module tb_dot_matrix_scanner;
  localparam int ROWS = 8, COLS = 8, SCAN_DIV = 4, BLANK = 2, DEB_BITS = 2, BLINK_BIT = 1;
  localparam int SLOT = 16, FRAME = 128, DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       blink = 1'b0;
  logic       key;
  logic [7:0] en, dataout;
  logic [1:0] pat_idx;

  dot_matrix_scanner_if #(.W(2)) kbus ();

  always #5 clk = ~clk;

  dot_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK),
    .DEB_BITS(DEB_BITS), .BLINK_BIT(BLINK_BIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_in  (kbus.raw),
    .blink   (blink),
    .key     (key),
    .en      (en),
    .dataout (dataout),
    .pat_idx (pat_idx)
  );

  logic [7:0] rom [4][8];
  initial begin
    rom[0] = '{8'h00, 8'h66, 8'h66, 8'h00, 8'h81, 8'h81, 8'h42, 8'h3C};
    rom[1] = '{8'h00, 8'h66, 8'h66, 8'h00, 8'h3C, 8'h42, 8'h81, 8'h81};
    rom[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    rom[3] = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: c clocks since reset release; displayed position is c-1.
  int         c = 0;
  logic [1:0] m_pat = 0, m_pend = 0, m_lvl = 0;
  int         m_run [2] = '{0, 0};
  logic [7:0] e_en = 8'hFF, e_dout = 8'h00;
  logic [1:0] e_pat = 2'd0;

  always @(posedge clk) begin
    if (!rst) begin
      c = 0; m_pat = 0; m_pend = 0; m_lvl = 0; m_run = '{0, 0};
      kbus.press = 2'b00;
      e_en = 8'hFF; e_dout = 8'h00; e_pat = 2'd0;
    end else begin
      int slot, row, frame;
      bit blanked;
      slot    = c % SLOT;
      row     = (c / SLOT) % ROWS;
      frame   = c / FRAME;
      blanked = (slot < BLANK) || (blink && ((frame >> BLINK_BIT) & 1) == 1);
      e_en    = blanked ? 8'hFF : ~(8'h01 << row);
      e_dout  = blanked ? 8'h00 : rom[m_pat][row];
      if (c % FRAME == 0) m_pat = m_pend;
      if (kbus.press == 2'b10) m_pend = m_pend + 2'd1;
      else if (kbus.press == 2'b01) m_pend = m_pend - 2'd1;
      for (int k = 0; k < 2; k++) begin
        if (kbus.raw[k] !== m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == DEB) begin
            m_lvl[k] = kbus.raw[k];
            m_run[k] = 0;
            kbus.press[k] = m_lvl[k];
          end else kbus.press[k] = 1'b0;
        end else begin
          m_run[k] = 0;
          kbus.press[k] = 1'b0;
        end
      end
      e_pat = m_pat;
      c++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("mon_rst_en", en, 8'hFF);
      chk("mon_rst_dout", dataout, 8'h00);
      chk("mon_rst_pat", {6'b0, pat_idx}, 8'h00);
    end else begin
      chk("mon_en", en, e_en);
      chk("mon_dout", dataout, e_dout);
      chk("mon_pat", {6'b0, pat_idx}, {6'b0, e_pat});
    end
    chk("mon_key", {7'b0, key}, 8'h00);
  end

  // Advance until the outputs show (row r, slot s); always moves at least one clock.
  task automatic wait_show(input int r, input int s);
    int tgt, n;
    tgt = (r * SLOT + s + 1) % FRAME;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((c % FRAME) != tgt && n < 400);
    if ((c % FRAME) != tgt) begin
      checks++; failures++;
      $display("FAIL wait_show timeout: row %0d slot %0d never reached", r, s);
    end
  endtask

  task automatic hold_keys(input logic [1:0] k, input int n);
    kbus.raw = k;
    repeat (n) @(negedge clk);
    kbus.raw = 2'b00;
  endtask

  task automatic release_check(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk); chk({tag, "_clk1_en"}, en, 8'hFF);
    @(negedge clk); chk({tag, "_clk2_en"}, en, 8'hFF);
    @(negedge clk); chk({tag, "_clk3_en"}, en, 8'hFE);
    chk({tag, "_clk3_dout"}, dataout, 8'h00);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_en"}, en, 8'hFF);
    chk({tag, "_dout"}, dataout, 8'h00);
    chk({tag, "_pat"}, {6'b0, pat_idx}, 8'h00);
    @(posedge clk);
    release_check({tag, "_rel"});
  endtask

  typedef struct {
    int         row;
    int         slot;
    logic [7:0] en;
    logic [7:0] dout;
  } vec_t;
  vec_t vecs [12];

  initial begin
    int lit, nz, f;
    vecs[0]  = '{0, 8, 8'hFE, 8'h00};
    vecs[1]  = '{1, 8, 8'hFD, 8'h66};
    vecs[2]  = '{2, 8, 8'hFB, 8'h66};
    vecs[3]  = '{3, 8, 8'hF7, 8'h00};
    vecs[4]  = '{4, 8, 8'hEF, 8'h81};
    vecs[5]  = '{5, 8, 8'hDF, 8'h81};
    vecs[6]  = '{6, 8, 8'hBF, 8'h42};
    vecs[7]  = '{7, 8, 8'h7F, 8'h3C};
    vecs[8]  = '{3, 0, 8'hFF, 8'h00};
    vecs[9]  = '{3, 1, 8'hFF, 8'h00};
    vecs[10] = '{3, 2, 8'hF7, 8'h00};
    vecs[11] = '{7, 15, 8'h7F, 8'h3C};
    kbus.raw = 2'b00;

    repeat (3) @(negedge clk);
    chk("init_en", en, 8'hFF);
    chk("init_dout", dataout, 8'h00);
    chk("init_pat", {6'b0, pat_idx}, 8'h00);
    release_check("init");
    @(negedge clk);
    async_reset("midrow_rst");

    foreach (vecs[i]) begin
      wait_show(vecs[i].row, vecs[i].slot);
      chk($sformatf("scan_r%0d_s%0d_en", vecs[i].row, vecs[i].slot), en, vecs[i].en);
      chk($sformatf("scan_r%0d_s%0d_dout", vecs[i].row, vecs[i].slot), dataout, vecs[i].dout);
    end

    // Press next in row 3: current frame keeps pattern 0.
    wait_show(3, 0);
    hold_keys(2'b10, 6);
    wait_show(4, 8); chk("tear_r4_old", dataout, 8'h81); chk("tear_pat_old", {6'b0, pat_idx}, 8'h00);
    wait_show(7, 8); chk("tear_r7_old", dataout, 8'h3C);
    wait_show(4, 8); chk("tear_r4_new", dataout, 8'h3C); chk("tear_pat_new", {6'b0, pat_idx}, 8'h01);

    wait_show(1, 0); hold_keys(2'b10, 3);
    wait_show(0, 8); chk("deb_short", {6'b0, pat_idx}, 8'h01);
    wait_show(1, 0); hold_keys(2'b10, 5);
    wait_show(0, 8); chk("deb_long_pat", {6'b0, pat_idx}, 8'h02); chk("deb_long_dout", dataout, 8'hFF);
    wait_show(1, 0);
    hold_keys(2'b10, 3); hold_keys(2'b00, 1); hold_keys(2'b10, 3);
    wait_show(0, 8); chk("deb_bounce", {6'b0, pat_idx}, 8'h02);

    // Pending change must be dropped by a mid-frame reset.
    wait_show(1, 0); hold_keys(2'b10, 5);
    wait_show(4, 0);
    async_reset("discard_rst");
    wait_show(0, 8);
    wait_show(0, 8); chk("rst_discard", {6'b0, pat_idx}, 8'h00);

    wait_show(1, 0); hold_keys(2'b01, 5);
    wait_show(0, 8); chk("wrap_pat", {6'b0, pat_idx}, 8'h03); chk("wrap_r0", dataout, 8'hAA);
    wait_show(1, 8); chk("wrap_r1", dataout, 8'h55);
    wait_show(1, 0); hold_keys(2'b11, 5);
    wait_show(0, 8); chk("simul_pat", {6'b0, pat_idx}, 8'h03);

    blink = 1'b1;
    wait_show(7, 15);
    for (int fr = 0; fr < 4; fr++) begin
      f = c / FRAME;
      lit = 0; nz = 0;
      repeat (FRAME) begin
        @(negedge clk);
        if (en != 8'hFF) lit++;
        if (dataout != 8'h00) nz++;
      end
      chk($sformatf("blink_f%0d_lit", f), 8'(lit), ((f >> BLINK_BIT) & 1) ? 8'd0 : 8'd112);
      chk($sformatf("blink_f%0d_dout", f), 8'(nz), ((f >> BLINK_BIT) & 1) ? 8'd0 : 8'd112);
    end
    blink = 1'b0;

    repeat (300) begin
      kbus.raw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) blink = ~blink;
      repeat ($urandom_range(1, 8)) @(negedge clk);
    end
    kbus.raw = 2'b00;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dot_matrix_scanner.md
DOT_MATRIX_SCANNER -- requirements
Module: dot_matrix_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of scanned rows (2..16).
REQ-002 SHALL have parameter COLS, default 8, column width of dataout (1..16).
REQ-003 SHALL have parameter SCAN_DIV, default 13, log2 of clocks per row slot.
REQ-004 SHALL have parameter BLANK, default 16, blanking clocks at start of each row slot (< 2^SCAN_DIV).
REQ-005 SHALL have parameter DEB_BITS, default 16, log2 of key debounce stable time in clocks.
REQ-006 SHALL have parameter BLINK_BIT, default 5, frame-counter bit driving blink.
REQ-007 SHALL have port list, in order:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- key_in  input  2  raw pushbuttons, high = pressed; [1] = next pattern, [0] = previous pattern.
- blink  input  1  high = blink mode enabled.
- key  output  1  key-matrix common line, constant 0.
- en  output  ROWS  row enables, active-low one-hot.
- dataout  output  COLS  column data, high = LED on.
- pat_idx  output  2  currently displayed pattern index.

Function
REQ-008 SHALL count clocks in a SCAN_DIV-bit slot counter; on wrap, row index SHALL advance, and row ROWS-1 SHALL wrap to 0.
REQ-009 SHALL define a frame as row 0 through row ROWS-1; a frame counter SHALL increment on each row ROWS-1 to row 0 wrap.
REQ-010 SHALL, while the slot counter < BLANK, drive en all ones and dataout all zeros (anti-ghosting).
REQ-011 SHALL otherwise drive en with bit[row] = 0 and all other bits 1, and dataout = ROM[pat_idx][row].
REQ-012 SHALL register en and dataout, giving exactly one clock of latency from the counter state.
REQ-013 SHALL, when blink = 1 and frame counter bit BLINK_BIT = 1, hold en all ones and dataout zero for the whole frame.
REQ-014 SHALL debounce each key_in bit independently: the debounced level changes only after the raw level has differed from it for 2^DEB_BITS consecutive clocks, and any bounce restarts the count.
REQ-015 SHALL generate a one-clock press pulse on each debounced 0 to 1 transition.
REQ-016 SHALL, on a next pulse, set the pending index to pat_idx+1 mod 4; on a prev pulse, pat_idx-1 mod 4 (3 to 0 wrap, 0 to 3 wrap).
REQ-017 SHALL ignore both pulses when they occur in the same clock.
REQ-018 SHALL apply the pending index to pat_idx only at the first clock of row 0 of a frame (tear-free); a later press before that boundary SHALL be computed relative to the pending index.
REQ-019 SHALL define ROM rows 0..7 in hex as follows, with bit 7 = dataout[7]:
- pat 0 (smile): 00 66 66 00 81 81 42 3C.
- pat 1 (frown): 00 66 66 00 3C 42 81 81.
- pat 2 (all on): FF x8.
- pat 3 (checker): AA 55 AA 55 AA 55 AA 55.
REQ-020 SHALL, for rows >= 8, output ROM data 0; for COLS < 8, output the low COLS bits; for COLS > 8, zero-extend the upper bits.
REQ-021 SHALL drive key constantly 0.

Reset
REQ-022 SHALL, while rst = 0, asynchronously force the following, all remaining so until the first rising clk edge after release:
- slot, row and frame counters: 0.
- en: all ones.
- dataout: 0.
- pat_idx and pending index: 0.
- debounced levels: 0.
- debounce counters: 0.
REQ-023 SHALL, on reset asserted mid-frame, discard any pending pattern change.

Structure
REQ-024 SHALL place the pattern ROM constants, the pattern-index width (2), and the pattern count (4) in a shared package dot_matrix_pkg.
REQ-025 SHALL implement debounce and edge detection in one sub-module, key_debounce, instantiated once per key bit.
REQ-026 SHALL implement the ROM as a combinational function of (pat_idx, row) inside dot_matrix_scanner.

Verification (ROWS=8, COLS=8, SCAN_DIV=4, BLANK=2, DEB_BITS=2, BLINK_BIT=1)
REQ-027 SHALL check reset: rst low at cycle 5 mid-row -> en=FF, dataout=00 and pat_idx=0 immediately; the first lit row after release is row 0 at clock 3.
REQ-028 SHALL check scan: with no keys, en sequence FE,FD,...,7F, each slot 16 clocks with the first 2 blank, repeating; dataout per row = 00 66 66 00 81 81 42 3C.
REQ-029 SHALL check debounce: key_in[1] pulsed high for 3 clocks -> no change; held 5 clocks -> exactly one next pulse; bounce 1-0-1 -> count restarts.
REQ-030 SHALL check tear-free switching: next pressed during row 3 -> rows 3..7 still show pat 0, next frame shows pat 1 (row 4 = 3C), pat_idx=1.
REQ-031 SHALL check wrap and simultaneous keys: prev from pat 0 -> pat_idx=3 and rows AA/55; both keys pressed in the same clock -> pat_idx unchanged.
REQ-032 SHALL check blink: blink=1 -> frames alternate lit and fully blanked (en=FF, dataout=00 for 128 clocks).
